audiodac_burst_sched: RTL and testbench
=======================================

// Module: audiodac_burst_sched
// PURPOSE
//  Host-side burst scheduler in front of the audiodac sample FIFO.
//  Shares the FIFO write port between two 16b sample sources (0 = host stream, 1 = aux/playback).
//  Bursts are granted round-robin: one source fills the FIFO from empty to full,
//  then the scheduler waits for empty again. A zero sample is inserted on underrun.
// PARAMETERS
//  MAX_BURST   16  max words per burst, 1..255; burst also ends on fifo_full_i
//  UNDER_WAIT  8   cycles fifo_empty_i may stay high with no valid source before a zero word is inserted, 1..255
// PORTS
//  CLK            in   1   clock; all logic on rising edge
//  RESET_N        in   1   synchronous, active-low reset
//  src0_data_i    in   16  source 0 sample, two's complement
//  src0_valid_i   in   1   source 0 has a sample
//  src0_ready_o   out  1   1-cycle pulse: src0 sample consumed
//  src1_data_i    in   16  source 1 sample
//  src1_valid_i   in   1   source 1 has a sample
//  src1_ready_o   out  1   1-cycle pulse: src1 sample consumed
//  fifo_o         out  16  word to audiodac fifo_i
//  fifo_rdy_o     out  1   to audiodac fifo_rdy_i
//  fifo_ack_i     in   1   from audiodac fifo_ack_o
//  fifo_full_i    in   1   from audiodac fifo_full_o
//  fifo_empty_i   in   1   from audiodac fifo_empty_o
//  grant_o        out  2   one-hot active burst owner; 00 = none
//  underrun_o     out  1   1-cycle pulse when a zero word is inserted
//  underrun_cnt_o out  8   saturating count of inserted zero words
// BEHAVIOUR
//  Reset: all outputs 0. FSM = IDLE. RR pointer = 0, so src0 has priority first.
//  States:
//   IDLE: if fifo_empty_i -> ARB.
//   ARB: pick the valid source. Both valid: RR pointer wins. Grant it and clear the word count -> LOAD.
//     Neither valid: count cycles. At UNDER_WAIT -> LOAD with a zero word, grant_o=00.
//   LOAD: latch the word into fifo_o. Pulse the granted srcN_ready_o (none for a zero word).
//     Set fifo_rdy_o=1 -> WAIT_ACK.
//   WAIT_ACK: hold fifo_o and fifo_rdy_o until fifo_ack_i=1 is sampled.
//     Then fifo_rdy_o=0, word count +1 -> REL.
//   REL: wait for fifo_ack_i=0.
//     Then go to IDLE if any of these: fifo_full_i, word count == MAX_BURST, granted source not valid, or zero-word burst.
//     In that case toggle the RR pointer away from the granted source (no toggle for a zero word) and grant_o=00.
//     Otherwise -> LOAD with the same source.
//  fifo_rdy_o never rises while fifo_ack_i=1. fifo_o is stable while fifo_rdy_o=1.
//  Minimum is 3 cycles per word plus FIFO ack latency.
//  A source is never consumed while fifo_full_i=1. The check is made in REL before looping to LOAD.
//  Zero-word insertion: exactly one word per UNDER_WAIT expiry. The wait counter clears on any grant.
//    underrun_o pulses in LOAD. underrun_cnt_o holds at 255.
//  A source dropping valid mid-burst ends the burst cleanly. It does not trigger an underrun until the FIFO drains.
//  Reset mid-transfer: fifo_rdy_o drops the next cycle and the in-flight word is discarded.
//    The source has already seen ready, so the word is lost by design.
// TESTING
//  src0 always valid, ramp 1,2,3..., FIFO depth 8 -> 8 words written in order, burst ends on full.
//    Grant returns only after empty.
//  Both sources always valid -> bursts alternate src0, src1, src0. grant_o goes 01, 10, 01.
//  MAX_BURST=4 with a deep FIFO -> exactly 4 ready pulses per burst, then re-arbitration.
//  No source valid, FIFO empty -> zero word after UNDER_WAIT=8 cycles. underrun_o pulses and underrun_cnt_o = 1.
//    After 300 expiries underrun_cnt_o = 255.
//  Delay fifo_ack_i by 5 cycles -> fifo_rdy_o/fifo_o held stable, no second srcN_ready_o pulse.
//  RESET_N low during WAIT_ACK -> all outputs 0 next cycle, FSM IDLE, RR pointer = src0.

Source files
------------

// File: rtl/audiodac_burst_sched.sv
// Round-robin burst scheduler sharing the audiodac sample FIFO write port between two
// 16-bit sources, inserting a zero word when the FIFO sits empty with nobody to feed it.
module audiodac_burst_sched #(
    parameter int MAX_BURST  = 16,
    parameter int UNDER_WAIT = 8
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] src0_data_i,
    input  logic        src0_valid_i,
    output logic        src0_ready_o,
    input  logic [15:0] src1_data_i,
    input  logic        src1_valid_i,
    output logic        src1_ready_o,
    output logic [15:0] fifo_o,
    output logic        fifo_rdy_o,
    input  logic        fifo_ack_i,
    input  logic        fifo_full_i,
    input  logic        fifo_empty_i,
    output logic [1:0]  grant_o,
    output logic        underrun_o,
    output logic [7:0]  underrun_cnt_o
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LOAD,
        S_WAIT_ACK,
        S_REL
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  grant_reg, grant_next;
    logic        rr_reg, rr_next;          // 1: src1 wins a tie
    logic        zero_reg, zero_next;      // current burst is a single inserted zero word
    logic [7:0]  word_cnt_reg, word_cnt_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic [15:0] word_reg, word_next;
    logic [7:0]  under_cnt_reg, under_cnt_next;

    logic [1:0]  src_valid;
    logic [1:0]  src_ready;
    logic        load_src;
    logic        burst_end;

    assign src_valid = {src1_valid_i, src0_valid_i};
    assign burst_end = fifo_full_i || (word_cnt_reg == 8'(MAX_BURST))
                    || ((grant_reg & src_valid) == 2'b00) || zero_reg;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_reg     <= S_IDLE;
            grant_reg     <= 2'b00;
            rr_reg        <= 1'b0;
            zero_reg      <= 1'b0;
            word_cnt_reg  <= 8'd0;
            wait_cnt_reg  <= 8'd0;
            word_reg      <= 16'd0;
            under_cnt_reg <= 8'd0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            rr_reg        <= rr_next;
            zero_reg      <= zero_next;
            word_cnt_reg  <= word_cnt_next;
            wait_cnt_reg  <= wait_cnt_next;
            word_reg      <= word_next;
            under_cnt_reg <= under_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        rr_next        = rr_reg;
        zero_next      = zero_reg;
        word_cnt_next  = word_cnt_reg;
        wait_cnt_next  = wait_cnt_reg;
        word_next      = word_reg;
        under_cnt_next = under_cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (fifo_empty_i) state_next = S_ARB;
            end
            S_ARB: begin
                if (src_valid != 2'b00) begin
                    grant_next    = (src_valid == 2'b11) ? (rr_reg ? 2'b10 : 2'b01) : src_valid;
                    zero_next     = 1'b0;
                    word_cnt_next = 8'd0;
                    wait_cnt_next = 8'd0;
                    state_next    = S_LOAD;
                end else if (!fifo_empty_i) begin
                    // FIFO no longer empty: the underrun wait restarts from IDLE
                    wait_cnt_next = 8'd0;
                    state_next    = S_IDLE;
                end else if (wait_cnt_reg == 8'(UNDER_WAIT - 1)) begin
                    grant_next    = 2'b00;
                    zero_next     = 1'b1;
                    word_cnt_next = 8'd0;
                    wait_cnt_next = 8'd0;
                    state_next    = S_LOAD;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            S_LOAD: begin
                word_next  = zero_reg ? 16'd0 : (grant_reg[1] ? src1_data_i : src0_data_i);
                if (zero_reg && (under_cnt_reg != 8'hFF)) under_cnt_next = under_cnt_reg + 8'd1;
                state_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (fifo_ack_i) begin
                    word_cnt_next = word_cnt_reg + 8'd1;
                    state_next    = S_REL;
                end
            end
            S_REL: begin
                if (!fifo_ack_i) begin
                    if (burst_end) begin
                        if (!zero_reg) rr_next = grant_reg[0];
                        grant_next = 2'b00;
                        zero_next  = 1'b0;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_LOAD;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        load_src   = (state_reg == S_LOAD) && !zero_reg;
        underrun_o = (state_reg == S_LOAD) && zero_reg;
        fifo_rdy_o = (state_reg == S_WAIT_ACK);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign src_ready[gi] = load_src & grant_reg[gi];
        end
    endgenerate

    assign src0_ready_o   = src_ready[0];
    assign src1_ready_o   = src_ready[1];
    assign fifo_o         = word_reg;
    assign grant_o        = grant_reg;
    assign underrun_cnt_o = under_cnt_reg;
endmodule

// File: tb/tb_audiodac_burst_sched.sv
// Bench for audiodac_burst_sched: behavioural sources, an acking FIFO model and a
// word scoreboard, driven through directed phases and a randomized tail.
module tb_audiodac_burst_sched;
    localparam int MAXB = 12;
    localparam int UW   = 8;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [15:0] src0_data_i = 16'd0, src1_data_i = 16'd0;
    logic        src0_valid_i = 1'b0, src1_valid_i = 1'b0;
    logic        fifo_ack_i = 1'b0, fifo_full_i = 1'b0, fifo_empty_i = 1'b1;
    logic        src0_ready_o, src1_ready_o, fifo_rdy_o, underrun_o;
    logic [15:0] fifo_o;
    logic [1:0]  grant_o;
    logic [7:0]  underrun_cnt_o;

    audiodac_burst_sched #(.MAX_BURST(MAXB), .UNDER_WAIT(UW)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .src0_data_i(src0_data_i), .src0_valid_i(src0_valid_i), .src0_ready_o(src0_ready_o),
        .src1_data_i(src1_data_i), .src1_valid_i(src1_valid_i), .src1_ready_o(src1_ready_o),
        .fifo_o(fifo_o), .fifo_rdy_o(fifo_rdy_o), .fifo_ack_i(fifo_ack_i),
        .fifo_full_i(fifo_full_i), .fifo_empty_i(fifo_empty_i),
        .grant_o(grant_o), .underrun_o(underrun_o), .underrun_cnt_o(underrun_cnt_o)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // source model: mode 0 never valid, 1 always valid, 2 random; valid only drops on consumption
    logic [15:0] sdata [2];
    logic        svalid [2];
    int          smode [2];
    bit          pend [2];

    // FIFO / audiodac model
    logic [15:0] fq[$];
    logic [15:0] expq[$];
    int          depth = 8;
    bit          drain_en = 0;
    int          drain_per = 2, drain_cnt = 0;
    int          ack_delay = 0, ack_wait = 0;
    logic [15:0] held = 16'd0;
    bit          prev_rdy = 0;

    // arbitration / underrun model
    logic [1:0]  prev_grant = 2'b00;
    logic [1:0]  glog[$];
    bit          rr_m = 0;
    int          burst_len = 0, last_len = 0, bursts_done = 0;
    int          uc_m = 0, cyc = 0, last_ur = -1;
    bit          gap_on = 0, rand_mode = 0;

    function automatic logic want_valid(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic set_mode(input int i, input int m);
        smode[i] = m;
        if (m == 0) svalid[i] = 1'b0;
    endtask

    // one clock of environment, evaluated on the falling edge
    task automatic env();
        logic [1:0]  exp_g;
        logic [15:0] tmp;
        int          k;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (pend[i]) begin
                sdata[i]  = sdata[i] + 16'd1;
                svalid[i] = want_valid(smode[i]);
                pend[i]   = 0;
            end
        end
        if (!RESET_N) begin
            expq.delete();
            rr_m = 0; uc_m = 0; prev_grant = 2'b00; prev_rdy = 0;
            burst_len = 0; fifo_ack_i = 1'b0; ack_wait = 0;
        end else begin
            if (grant_o != prev_grant) begin
                if (prev_grant != 2'b00) begin
                    chk("grant_release", grant_o, 2'b00);
                    rr_m = prev_grant[0];
                    last_len = burst_len;
                    bursts_done++;
                    chk("burst_le_max", (burst_len <= MAXB), 1);
                    if (rand_mode) begin
                        depth     = $urandom_range(2, 16);
                        drain_per = $urandom_range(1, 4);
                    end
                end else begin
                    if (svalid[0] && svalid[1]) exp_g = rr_m ? 2'b10 : 2'b01;
                    else exp_g = {svalid[1], svalid[0]};
                    chk("grant_rr", grant_o, exp_g);
                    chk("grant_on_empty", fq.size(), 0);
                    glog.push_back(grant_o);
                    burst_len = 0;
                end
                prev_grant = grant_o;
            end
            if (src0_ready_o || src1_ready_o) begin
                chk("ready_owner", {src1_ready_o, src0_ready_o}, grant_o);
                chk("ready_not_full", fifo_full_i, 0);
                chk("ready_not_waiting", fifo_rdy_o, 0);
                k = src1_ready_o ? 1 : 0;
                chk("ready_valid", svalid[k], 1);
                expq.push_back(sdata[k]);
                pend[k] = 1;
                burst_len++;
            end
            if (underrun_o) begin
                chk("underrun_no_grant", grant_o, 2'b00);
                uc_m++;
                // LOAD, WAIT_ACK, REL with immediate ack, one IDLE cycle, then UW cycles in ARB
                if (gap_on && last_ur >= 0) chk("underrun_gap", cyc - last_ur, UW + 4);
                last_ur = cyc;
                expq.push_back(16'd0);
            end
            if (fifo_rdy_o && !prev_rdy) begin
                chk("rdy_rise_ack_low", fifo_ack_i, 0);
                held = fifo_o;
                ack_wait = 0;
                if (rand_mode) ack_delay = $urandom_range(0, 3);
            end else if (fifo_rdy_o) begin
                chk("fifo_o_stable", fifo_o, held);
            end
            if (fifo_rdy_o && !fifo_ack_i) begin
                if (ack_wait >= ack_delay && fq.size() < depth) begin
                    fq.push_back(fifo_o);
                    if (expq.size() == 0) chk("sb_has_expect", 0, 1);
                    else chk("sb_word", fifo_o, expq.pop_front());
                    fifo_ack_i = 1'b1;
                end else begin
                    ack_wait++;
                end
            end else if (!fifo_rdy_o && fifo_ack_i) begin
                fifo_ack_i = 1'b0;
            end
            prev_rdy = fifo_rdy_o;
        end
        if (drain_en) begin
            drain_cnt++;
            if (drain_cnt >= drain_per && fq.size() > 0) begin
                tmp = fq.pop_front();
                drain_cnt = 0;
            end
        end
        fifo_full_i  = (fq.size() >= depth);
        fifo_empty_i = (fq.size() == 0);
        for (int i = 0; i < 2; i++) if (!svalid[i]) svalid[i] = want_valid(smode[i]);
        src0_data_i  = sdata[0];
        src1_data_i  = sdata[1];
        src0_valid_i = svalid[0];
        src1_valid_i = svalid[1];
    endtask

    task automatic step();
        @(negedge CLK);
        env();
    endtask

    task automatic wait_burst(input int budget);
        int target = bursts_done + 1;
        int n = 0;
        while (bursts_done < target && n < budget) begin step(); n++; end
        if (bursts_done < target) chk("timeout_burst", 0, 1);
    endtask

    task automatic wait_grant(input int budget);
        int n = 0;
        while (grant_o == 2'b00 && n < budget) begin step(); n++; end
        if (grant_o == 2'b00) chk("timeout_grant", 0, 1);
    endtask

    task automatic wait_rdy(input logic level, input int budget);
        int n = 0;
        while (fifo_rdy_o != level && n < budget) begin step(); n++; end
        if (fifo_rdy_o != level) chk("timeout_rdy", 0, 1);
    endtask

    task automatic wait_uc(input int target, input int budget);
        int n = 0;
        while (uc_m < target && n < budget) begin step(); n++; end
        if (uc_m < target) chk("timeout_underrun", 0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, grant_o, 0);
        chk({tag, "_rdy"}, fifo_rdy_o, 0);
        chk({tag, "_ready"}, {src1_ready_o, src0_ready_o}, 0);
        chk({tag, "_underrun"}, underrun_o, 0);
        chk({tag, "_ucnt"}, underrun_cnt_o, 0);
        chk({tag, "_fifo_o"}, fifo_o, 0);
    endtask

    initial begin
        int cnt;
        sdata[0] = 16'd1;     sdata[1] = 16'h1000;
        smode[0] = 1;         smode[1] = 0;
        svalid[0] = 1'b1;     svalid[1] = 1'b0;
        pend[0] = 0;          pend[1] = 0;
        src0_data_i = sdata[0]; src0_valid_i = 1'b1;
        src1_data_i = sdata[1]; src1_valid_i = 1'b0;

        repeat (3) step();
        chk_all_zero("reset");
        RESET_N = 1'b1;

        // ramp from src0 into a depth-8 FIFO that is not draining
        wait_burst(300);
        chk("ramp_burst_len", last_len, 8);
        chk("ramp_fifo_level", fq.size(), 8);
        for (int i = 0; i < 8 && i < fq.size(); i++) chk("ramp_order", fq[i], i + 1);
        repeat (20) step();
        chk("no_grant_until_empty", grant_o, 2'b00);
        drain_en = 1;
        wait_grant(300);
        chk("regrant_src0", grant_o, 2'b01);

        // both sources valid: owners alternate
        set_mode(1, 1);
        glog.delete();
        cnt = 0;
        while (glog.size() < 4 && cnt < 3000) begin step(); cnt++; end
        if (glog.size() < 4) chk("timeout_alternate", 0, 1);
        for (int i = 1; i < glog.size() && i < 4; i++) chk("alternate", glog[i], glog[i-1] ^ 2'b11);

        // deep FIFO: bursts are cut at MAX_BURST
        wait_burst(1000);
        depth = 64;
        drain_per = 10;
        set_mode(1, 0);
        for (int b = 0; b < 2; b++) begin
            wait_burst(1500);
            chk("burst_maxlen", last_len, MAXB);
        end

        // nobody valid: periodic zero words and saturating count
        set_mode(0, 0);
        drain_per = 1;
        last_ur = -1;
        gap_on = 1;
        wait_uc(1, 500);
        repeat (2) step();
        chk("ucnt_first", underrun_cnt_o, 1);
        wait_uc(100, 2000);
        step();
        chk("ucnt_100", underrun_cnt_o, uc_m);
        wait_uc(300, 4000);
        repeat (2) step();
        chk("ucnt_sat", underrun_cnt_o, 255);
        gap_on = 0;

        // slow ack: fifo_rdy_o held for ack_delay+1 sampled cycles
        set_mode(0, 1);
        ack_delay = 5;
        for (int w = 0; w < 3; w++) begin
            wait_rdy(1'b0, 100);
            wait_rdy(1'b1, 200);
            cnt = 0;
            while (fifo_rdy_o && cnt < 50) begin cnt++; step(); end
            chk("ack_hold_cycles", cnt, ack_delay + 1);
        end

        // reset while waiting for ack
        set_mode(1, 1);
        ack_delay = 20;
        wait_rdy(1'b0, 100);
        wait_rdy(1'b1, 300);
        step();
        RESET_N = 1'b0;
        step();
        chk_all_zero("midreset");
        RESET_N = 1'b1;
        ack_delay = 0;
        wait_grant(300);
        chk("grant_after_reset", grant_o, 2'b01);

        // randomized traffic
        rand_mode = 1;
        set_mode(0, 2);
        set_mode(1, 2);
        repeat (2000) step();
        cnt = 0;
        while (underrun_o && cnt < 10) begin step(); cnt++; end
        chk("ucnt_random", underrun_cnt_o, (uc_m > 255) ? 255 : uc_m);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
